// File: rtl/dff_bank_arbiter_if.sv
// Request/grant/capture bundle between requesters and the shared-register arbiter.
// The master side belongs to the requesters, and the slave side belongs to the arbiter.
interface dff_bank_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_in;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        grant_out;
  logic [NUM_REQ-1:0]        ack_out;
  logic [DATA_W-1:0]         q_out;
  logic                      q_valid_out;
  logic [IDX_W-1:0]          owner_out;
  logic                      busy_out;

  modport master (
    output req_in, data_in,
    input  grant_out, ack_out, q_out, q_valid_out, owner_out, busy_out
  );

  modport slave (
    input  req_in, data_in,
    output grant_out, ack_out, q_out, q_valid_out, owner_out, busy_out
  );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter in front of a single shared flip-flop register.
// Each write passes through GRANT and then CAPTURE. The register loads only on entry to CAPTURE.
module dff_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  dff_bank_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [IDX_W-1:0]     r_ptr, w_ptr_next;
  logic [IDX_W-1:0]     r_win, w_win_next;
  logic [NUM_REQ-1:0]   r_grant, w_grant_next;
  logic [NUM_REQ-1:0]   r_ack, w_ack_next;
  logic [DATA_W-1:0]    r_q, w_q_next;
  logic                 r_q_valid, w_q_valid_next;
  logic [IDX_W-1:0]     r_owner, w_owner_next;
  logic                 r_busy, w_busy_next;

  logic [DATA_W-1:0]    w_data [NUM_REQ];
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [NUM_REQ-1:0]   w_req_masked;
  logic [IDX_W-1:0]     w_cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]   w_cand_req;
  logic                 w_sel_found;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [NUM_REQ-1:0]   w_sel_oh;
  logic [IDX_W-1:0]     w_ptr_inc;

  // Candidate gi is the requester that sits gi places above the priority pointer, with wrap-around.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_data[gi]     = bus.data_in[gi*DATA_W +: DATA_W];
    assign w_win_oh[gi]   = (r_win == IDX_W'(gi));
    assign w_sel_oh[gi]   = (w_sel_idx == IDX_W'(gi));
    assign w_cand_idx[gi] = IDX_W'((32'(r_ptr) + 32'(gi)) % 32'(NUM_REQ));
    assign w_cand_req[gi] = w_req_masked[w_cand_idx[gi]];
  end

  // While in CAPTURE, the requester being acknowledged cannot win again straight away.
  assign w_req_masked = bus.req_in & ~((r_state == ST_CAPTURE) ? w_win_oh : '0);

  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_cand_req[k]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand_idx[k];
      end
    end
  end

  assign w_ptr_inc = (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;

  always_comb begin
    w_state_next   = r_state;
    w_win_next     = r_win;
    w_ptr_next     = r_ptr;
    w_grant_next   = '0;
    w_ack_next     = '0;
    w_q_next       = r_q;
    w_q_valid_next = r_q_valid;
    w_owner_next   = r_owner;
    w_busy_next    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_found) begin
          w_state_next = ST_GRANT;
          w_win_next   = w_sel_idx;
          w_grant_next = w_sel_oh;
          w_busy_next  = 1'b1;
        end
      end
      ST_GRANT: begin
        // If the winner drops its request here, the access is abandoned and the pointer stays put.
        if (bus.req_in[r_win]) begin
          w_state_next   = ST_CAPTURE;
          w_q_next       = w_data[r_win];
          w_ack_next     = w_win_oh;
          w_owner_next   = r_win;
          w_q_valid_next = 1'b1;
          w_ptr_next     = w_ptr_inc;
          w_busy_next    = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (w_sel_found) begin
          w_state_next = ST_GRANT;
          w_win_next   = w_sel_idx;
          w_grant_next = w_sel_oh;
          w_busy_next  = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_win     <= '0;
      r_grant   <= '0;
      r_ack     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_owner   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_win     <= w_win_next;
      r_grant   <= w_grant_next;
      r_ack     <= w_ack_next;
      r_q       <= w_q_next;
      r_q_valid <= w_q_valid_next;
      r_owner   <= w_owner_next;
      r_busy    <= w_busy_next;
    end
  end

  assign bus.grant_out   = r_grant;
  assign bus.ack_out     = r_ack;
  assign bus.q_out       = r_q;
  assign bus.q_valid_out = r_q_valid;
  assign bus.owner_out   = r_owner;
  assign bus.busy_out    = r_busy;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter: reset, round-robin order, single write, wrap/skip, abort
// and an asynchronous reset pulse during CAPTURE. Inputs change and outputs are sampled on negedges.
module tb_dff_bank_arbiter;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  dff_bank_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  dff_bank_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int         own [5];
    logic [3:0] oh;
    own = '{0, 1, 2, 3, 0};

    // Reset with every requester asking
    rst_n       = 1'b0;
    bus.req_in  = 4'b1111;
    bus.data_in = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(bus.grant_out), 32'h0);
    chk("rst_ack",   32'(bus.ack_out),   32'h0);
    chk("rst_q",     32'(bus.q_out),     32'h00);
    chk("rst_valid", 32'(bus.q_valid_out), 32'h0);
    chk("rst_owner", 32'(bus.owner_out), 32'h0);
    chk("rst_busy",  32'(bus.busy_out),  32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 32'(bus.grant_out), 32'h1);
    chk("first_busy",  32'(bus.busy_out),  32'h1);

    // Round-robin: all four requesters ask; each drops for one cycle after its ack
    for (int i = 0; i < 5; i++) begin
      oh = 4'(1 << own[i]);
      bus.req_in = 4'b1111;
      @(negedge clk);
      $display("[TB] rr write %0d: owner=%0d q=%h ack=%b", i, bus.owner_out, bus.q_out, bus.ack_out);
      chk("rr_ack",   32'(bus.ack_out),   32'(oh));
      chk("rr_grant0", 32'(bus.grant_out), 32'h0);
      chk("rr_q",     32'(bus.q_out),     32'h10 + 32'(own[i]));
      chk("rr_owner", 32'(bus.owner_out), 32'(own[i]));
      chk("rr_valid", 32'(bus.q_valid_out), 32'h1);
      if (i < 4) begin
        bus.req_in = 4'b1111 & ~oh;
        @(negedge clk);
        chk("rr_next_grant", 32'(bus.grant_out), 32'(1 << own[i+1]));
      end else begin
        bus.req_in = 4'b0000;
        @(negedge clk);
        chk("rr_idle_busy",  32'(bus.busy_out),  32'h0);
        chk("rr_idle_grant", 32'(bus.grant_out), 32'h0);
      end
    end

    // Single write from requester 2 (the pointer is now 1)
    bus.data_in[23:16] = 8'hA5;
    bus.req_in = 4'b0100;
    @(negedge clk);
    chk("single_grant", 32'(bus.grant_out), 32'h4);
    @(negedge clk);
    $display("[TB] single write: owner=%0d q=%h", bus.owner_out, bus.q_out);
    chk("single_ack",   32'(bus.ack_out),   32'h4);
    chk("single_q",     32'(bus.q_out),     32'hA5);
    chk("single_owner", 32'(bus.owner_out), 32'h2);
    bus.req_in = 4'b0000;
    @(negedge clk);
    chk("single_idle", 32'(bus.busy_out), 32'h0);
    chk("single_hold", 32'(bus.q_out),    32'hA5);

    // Wrap and skip: the pointer is 3; requesters 0 and 1 ask
    bus.data_in[7:0]  = 8'h20;
    bus.data_in[15:8] = 8'h21;
    bus.req_in = 4'b0011;
    @(negedge clk);
    chk("wrap_grant0", 32'(bus.grant_out), 32'h1);
    @(negedge clk);
    $display("[TB] wrap write: owner=%0d q=%h", bus.owner_out, bus.q_out);
    chk("wrap_q0", 32'(bus.q_out), 32'h20);
    bus.req_in = 4'b0010;
    @(negedge clk);
    chk("wrap_grant1", 32'(bus.grant_out), 32'h2);
    chk("wrap_busy",   32'(bus.busy_out),  32'h1);
    @(negedge clk);
    $display("[TB] wrap write: owner=%0d q=%h", bus.owner_out, bus.q_out);
    chk("wrap_q1",     32'(bus.q_out),     32'h21);
    chk("wrap_owner1", 32'(bus.owner_out), 32'h1);
    bus.req_in = 4'b0000;
    @(negedge clk);

    // Abort: requester 0 drops while granted (the pointer is 2)
    bus.req_in = 4'b0001;
    @(negedge clk);
    chk("abort_grant", 32'(bus.grant_out), 32'h1);
    bus.req_in = 4'b0000;
    @(negedge clk);
    $display("[TB] abort: busy=%0d q=%h", bus.busy_out, bus.q_out);
    chk("abort_ack",   32'(bus.ack_out),   32'h0);
    chk("abort_busy",  32'(bus.busy_out),  32'h0);
    chk("abort_q",     32'(bus.q_out),     32'h21);
    chk("abort_owner", 32'(bus.owner_out), 32'h1);
    bus.data_in[7:0]  = 8'h30;
    bus.data_in[15:8] = 8'h31;
    bus.req_in = 4'b0011;
    @(negedge clk);
    chk("abort_ptr_kept", 32'(bus.grant_out), 32'h1);
    @(negedge clk);
    chk("post_abort_q", 32'(bus.q_out), 32'h30);
    bus.req_in = 4'b0010;
    @(negedge clk);
    chk("pre_rst_grant", 32'(bus.grant_out), 32'h2);
    @(negedge clk);
    chk("pre_rst_ack", 32'(bus.ack_out), 32'h2);
    chk("pre_rst_q",   32'(bus.q_out),   32'h31);

    // Asynchronous reset pulse during CAPTURE, placed between clock edges
    #1 rst_n = 1'b0;
    #1;
    $display("[TB] async reset: ack=%b q=%h valid=%0d", bus.ack_out, bus.q_out, bus.q_valid_out);
    chk("arst_ack",   32'(bus.ack_out),     32'h0);
    chk("arst_q",     32'(bus.q_out),       32'h0);
    chk("arst_valid", 32'(bus.q_valid_out), 32'h0);
    chk("arst_owner", 32'(bus.owner_out),   32'h0);
    chk("arst_busy",  32'(bus.busy_out),    32'h0);
    #2;
    bus.req_in = 4'b0000;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy",  32'(bus.busy_out),    32'h0);
    chk("post_rst_valid", 32'(bus.q_valid_out), 32'h0);
    chk("post_rst_q",     32'(bus.q_out),       32'h0);
    // The pointer is back at 0, so requester 1 beats requester 2
    bus.req_in = 4'b0110;
    @(negedge clk);
    chk("post_rst_grant", 32'(bus.grant_out), 32'h2);
    bus.req_in = 4'b0000;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
